store_align_unit: RTL

Store-side counterpart of the load extraction path in the mp1 datapath. Accepts one store (SB/SH/SW) per request, computes the byte-lane write data and byte-enable mask from the low address bits, and issues the write to data memory over the mem_write/mem_resp handshake. When built with split support, it turns word-crossing misaligned stores into two sequential aligned writes. Sits between the execute stage (rs2, ALU address, funct3) and the data-memory port.

---
 rtl/store_align_unit.sv | 100 ++++++++++
 1 files changed

// File: rtl/store_align_unit.sv
// store_align_unit: lane-aligns SB/SH/SW stores and issues them over mem_write/mem_resp; macro STORE_MISALIGN_SPLIT_EN enables misaligned and word-crossing support
module store_align_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] rs2_data,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  output logic        mem_write,
  input  logic        mem_resp,
  output logic        done,
  output logic        err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WR_LO = 2'd1;
`ifdef STORE_MISALIGN_SPLIT_EN
  localparam logic [1:0] WR_HI = 2'd2;
`endif
  logic [1:0]  state;
  logic [1:0]  off;
  logic [3:0]  size_mask;
  logic [3:0]  m_lo;
  logic [31:0] d_lo;
  logic        bad;
`ifdef STORE_MISALIGN_SPLIT_EN
  logic [3:0]  m_hi;
  logic [3:0]  hi_mask;
  logic [31:0] d_hi;
  logic [31:0] hi_data;
`endif
  assign off = addr[1:0];
  assign req_ready = state == IDLE && !rst;
  // byte-lane mask of the store width before shifting
  always_comb size_mask = funct3 == 3'b000 ? 4'b0001 : funct3 == 3'b001 ? 4'b0011 : 4'b1111;
`ifdef STORE_MISALIGN_SPLIT_EN
  assign {m_hi, m_lo} = {4'b0000, size_mask} << off;
  assign {d_hi, d_lo} = {32'b0, rs2_data} << {off, 3'b000};
  assign bad = funct3 > 3'b010;
`else
  assign m_lo = size_mask << off;
  assign d_lo = rs2_data << {off, 3'b000};
  assign bad = funct3 > 3'b010 || (funct3 == 3'b001 && off[0]) || (funct3 == 3'b010 && off != 2'b00);
`endif
  // accept a request, present the lo write, then the hi write if the store crosses a word
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      done            <= 1'b0;
      err             <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
      hi_mask         <= '0;
      hi_data         <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == IDLE) begin
        if (req_valid) begin
          if (bad) begin
            done <= 1'b1;
            err  <= 1'b1;
          end else begin
            state           <= WR_LO;
            mem_write       <= 1'b1;
            mem_address     <= {addr[31:2], 2'b00};
            mem_wdata       <= d_lo;
            mem_byte_enable <= m_lo;
`ifdef STORE_MISALIGN_SPLIT_EN
            hi_mask         <= m_hi;
            hi_data         <= d_hi;
`endif
          end
        end
      end else if (mem_resp) begin
`ifdef STORE_MISALIGN_SPLIT_EN
        if (state == WR_LO && |hi_mask) begin
          state           <= WR_HI;
          mem_address     <= mem_address + 32'd4;
          mem_wdata       <= hi_data;
          mem_byte_enable <= hi_mask;
        end else
`endif
        begin
          state           <= IDLE;
          mem_write       <= 1'b0;
          mem_byte_enable <= '0;
          done            <= 1'b1;
        end
      end
    end
  end
endmodule
